dh_exchange_ctrl: RTL
=====================

# dh_exchange_ctrl

Sequencer for a full Diffie-Hellman exchange over one shared modular-exponentiation engine (`test_32bits`-style: base/exponent/modulus in, `st` pulse, result out). It runs four exponentiations on the single engine in fixed order: RA = g^xa mod p, RB = g^xb mod p, KA = RB^xa mod p, KB = RA^xb mod p. It sits between the top-level key-exchange interface and the engine, latching operands, driving the engine handshake, policing engine latency and reporting the public values and shared keys.

## Interface
- W, 32, operand/result width (g, p, xa, xb, engine bus)
- TMO, 1024, max cycles from `eng_st` to `eng_done` before timeout (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- st  in  1  start pulse; sampled only in IDLE
- g, p, xa, xb  in  W each  generator, modulus, private exponents A/B
- busy  out  1  high from the cycle after accepted `st` until `done`
- done  out  1  one-cycle completion pulse (success or error)
- ra, rb, ka, kb  out  W each  public values and shared keys; held until next accepted `st`
- err  out  2  0 none, 1 bad modulus, 2 engine timeout, 3 key mismatch; valid with `done`, held
- eng_st  out  1  one-cycle engine start
- eng_base, eng_exp, eng_mod  out  W each  engine operands
- eng_res  in  W  engine result
- eng_done  in  1  engine completion strobe

## Operation
- States: IDLE, RA_REQ, RA_WAIT, RB_REQ, RB_WAIT, KA_REQ, KA_WAIT, KB_REQ, KB_WAIT, FIN.
- IDLE: on `st`=1, latch g, p, xa, xb; clear ra/rb/ka/kb/err. If latched p<2 (combinationally checked on input p), go FIN with err=1, no engine start. Otherwise go RA_REQ.
- X_REQ: `eng_st`=1 for exactly this cycle; operands set (RA: g,xa; RB: g,xb; KA: rb,xa; KB: ra,xb; mod always p). Next state X_WAIT.
- X_WAIT: operands held stable. On `eng_done`=1, capture `eng_res` into the matching result register, advance to next REQ (after KB_WAIT → FIN).
- `eng_done` outside WAIT states ignored.
- Watchdog: counter cleared in each REQ, increments in WAIT; reaching TMO without `eng_done` → FIN with err=2; partial results stay visible.
- FIN: `done`=1 one cycle, `busy`=0, → IDLE.
- `st` while busy ignored; `st` in same cycle as FIN ignored (accepted only in IDLE).
- Results are W-bit unsigned; no arithmetic in this block other than the watchdog counter (width clog2(TMO+1)).

## Timing
- Reset values: all outputs 0, state IDLE, watchdog 0. Reset mid-exchange aborts immediately; `eng_st` low from reset assertion; no `done` issued.
- `st` at edge n → RA_REQ in cycle n+1 (`eng_st`, `busy` high).
- Engine latency L = cycles from `eng_st` cycle to `eng_done` cycle (L≥1). Each exponentiation costs L+1 cycles; `done` at cycle n+1+4(L+1) after accept (n+1 for bad modulus).
- `eng_done` coincident with watchdog expiry: done wins, no timeout.

## Configuration
- `DH_KEY_CHECK_EN` defined: in FIN, if ka≠kb and err=0, err=3. Undefined: comparator absent, err never 3, ka/kb reported unchecked.

## Structure
- Package `dh_pkg`: state enum, err code constants (DH_ERR_NONE/BADMOD/TMO/KEYMIS), default W.
- Sub-module `dh_watchdog`: loadable up-counter with clear, enable, expiry flag, parameter TMO.

## Test plan
- g=17, p=5, xa=6, xb=3, engine model L=8 → ra=4, rb=3, ka=4, kb=4, err=0, done at accept+37.
- p=1 with st → done one cycle after accept, err=1, eng_st never pulses.
- Engine model never asserts eng_done, TMO=20 → done, err=2, ra=0, busy drops.
- rst asserted during KA_WAIT → all outputs 0 next sample, new st then completes normally.
- st pulses during busy and in FIN cycle → ignored; single done; results unchanged.
- With DH_KEY_CHECK_EN, engine model corrupts KB result → err=3; without macro, same stimulus → err=0.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman exchange sequencer.
package dh_pkg;

  localparam int DH_W = 32;

  typedef enum logic [3:0] {
    IDLE,
    RA_REQ,
    RA_WAIT,
    RB_REQ,
    RB_WAIT,
    KA_REQ,
    KA_WAIT,
    KB_REQ,
    KB_WAIT,
    FIN
  } dh_state_e;

  localparam logic [1:0] DH_ERR_NONE   = 2'd0;
  localparam logic [1:0] DH_ERR_BADMOD = 2'd1;
  localparam logic [1:0] DH_ERR_TMO    = 2'd2;
  localparam logic [1:0] DH_ERR_KEYMIS = 2'd3;

  function automatic logic is_wait(input dh_state_e s);
    return (s == RA_WAIT) || (s == RB_WAIT) || (s == KA_WAIT) || (s == KB_WAIT);
  endfunction

endpackage

// File: rtl/dh_watchdog.sv
// Engine-latency watchdog: up-counter cleared per request, counts while waiting,
// flags expiry on the TMO-th waiting cycle after the engine start.
module dh_watchdog #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;

  // the request cycle itself is cycle 0, so waiting cycle k sees cnt_q == k-1
  assign expired = en && (cnt_q == CW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/dh_exchange_ctrl.sv
// Sequences RA, RB, KA, KB exponentiations over one shared mod-exp engine.
// Optional DH_KEY_CHECK_EN adds a ka/kb agreement check reported as err=3.
//
//   state   | meaning
//   IDLE    | waiting for st; operands latched and modulus checked on accept
//   X_REQ   | one-cycle engine start for exponentiation X (RA, RB, KA, KB)
//   X_WAIT  | operands held, watchdog running, waiting for eng_done
//   FIN     | done pulse, then back to IDLE
module dh_exchange_ctrl
  import dh_pkg::*;
#(
  parameter int W   = DH_W,
  parameter int TMO = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic [W-1:0] g,
  input  logic [W-1:0] p,
  input  logic [W-1:0] xa,
  input  logic [W-1:0] xb,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb,
  output logic [W-1:0] ka,
  output logic [W-1:0] kb,
  output logic [1:0]   err,
  output logic         eng_st,
  output logic [W-1:0] eng_base,
  output logic [W-1:0] eng_exp,
  output logic [W-1:0] eng_mod,
  input  logic [W-1:0] eng_res,
  input  logic         eng_done
);

  dh_state_e state_q, state_d;

  logic [W-1:0] g_q, p_q, xa_q, xb_q;
  logic [W-1:0] ra_q, rb_q, ka_q, kb_q;
  logic [1:0]   err_q;
  logic         wd_clr, wd_en, wd_exp;
  logic         bad_mod;

  assign bad_mod = (p < W'(2));

  dh_watchdog #(.TMO(TMO)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    eng_st   = 1'b0;
    eng_base = '0;
    eng_exp  = '0;
    eng_mod  = '0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;

    unique case (state_q)
      RA_REQ, RA_WAIT: begin eng_base = g_q;  eng_exp = xa_q; end
      RB_REQ, RB_WAIT: begin eng_base = g_q;  eng_exp = xb_q; end
      KA_REQ, KA_WAIT: begin eng_base = rb_q; eng_exp = xa_q; end
      KB_REQ, KB_WAIT: begin eng_base = ra_q; eng_exp = xb_q; end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (st) state_d = bad_mod ? FIN : RA_REQ;
      end
      RA_REQ, RB_REQ, KA_REQ, KB_REQ: begin
        busy    = 1'b1;
        eng_st  = 1'b1;
        eng_mod = p_q;
        wd_clr  = 1'b1;
        state_d = dh_state_e'(state_q + 4'd1);
      end
      RA_WAIT, RB_WAIT, KA_WAIT, KB_WAIT: begin
        busy    = 1'b1;
        eng_mod = p_q;
        wd_en   = 1'b1;
        // a completion landing on the expiry cycle still counts as success
        if (eng_done)    state_d = dh_state_e'(state_q + 4'd1);
        else if (wd_exp) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q   <= '0;
      p_q   <= '0;
      xa_q  <= '0;
      xb_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      ka_q  <= '0;
      kb_q  <= '0;
      err_q <= DH_ERR_NONE;
    end else if (state_q == IDLE) begin
      if (st) begin
        g_q   <= g;
        p_q   <= p;
        xa_q  <= xa;
        xb_q  <= xb;
        ra_q  <= '0;
        rb_q  <= '0;
        ka_q  <= '0;
        kb_q  <= '0;
        err_q <= bad_mod ? DH_ERR_BADMOD : DH_ERR_NONE;
      end
    end else if (is_wait(state_q)) begin
      if (eng_done) begin
        unique case (state_q)
          RA_WAIT: ra_q <= eng_res;
          RB_WAIT: rb_q <= eng_res;
          KA_WAIT: ka_q <= eng_res;
          KB_WAIT: begin
            kb_q <= eng_res;
`ifdef DH_KEY_CHECK_EN
            // resolved here so err is already valid alongside done in FIN
            if ((eng_res != ka_q) && (err_q == DH_ERR_NONE)) err_q <= DH_ERR_KEYMIS;
`endif
          end
          default: ;
        endcase
      end else if (wd_exp) begin
        err_q <= DH_ERR_TMO;
      end
    end
  end

  assign ra  = ra_q;
  assign rb  = rb_q;
  assign ka  = ka_q;
  assign kb  = kb_q;
  assign err = err_q;

endmodule
